// File: rtl/lfsr_pkg.sv
// Shared definitions for the 3-bit XNOR LFSR generator and its stream checker.
// Holds the recurrence so generator, checker and benches predict identically.
package lfsr_pkg;

    localparam int          LFSR_W      = 3;
    localparam logic [2:0]  LFSR_LOCKUP = 3'b111;

    typedef enum logic [1:0] {
        HUNT   = 2'b00,
        VERIFY = 2'b01,
        LOCKED = 2'b10
    } chk_state_t;

    // The all-ones state is the XNOR lockup point, so it reloads from seed instead of shifting.
    function automatic logic [LFSR_W-1:0] lfsr3_next(
        input logic [LFSR_W-1:0] cur,
        input logic [LFSR_W-1:0] seed
    );
        logic [LFSR_W-1:0] nxt;
        if (cur == LFSR_LOCKUP) begin
            nxt = seed;
        end else begin
            nxt = {cur[1:0], ~(cur[2] ^ cur[1])};
        end
        return nxt;
    endfunction

endpackage

// File: rtl/lfsr_3bits_checker.sv
// Self-synchronising checker for the 3-bit XNOR LFSR stream: hunts, verifies, locks, counts misses.
// Optional macro LFSR_CHK_SAMPLE_CNT_EN adds a wrapping 16-bit count of accepted samples.
module lfsr_3bits_checker
    import lfsr_pkg::*;
#(
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 2,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [LFSR_W-1:0]    seed,
    input  logic                 sample_valid,
    input  logic [LFSR_W-1:0]    sample,
    output logic                 locked,
    output logic                 mismatch,
`ifdef LFSR_CHK_SAMPLE_CNT_EN
    output logic [15:0]          sample_count,
`endif
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [3:0]           LOCK_TARGET = 4'(LOCK_COUNT);
    localparam logic [3:0]           LOSS_TARGET = 4'(LOSS_COUNT);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX     = {ERR_CNT_W{1'b1}};

    chk_state_t           state_r,     state_s;
    logic [LFSR_W-1:0]    prev_r,      prev_s;
    logic [3:0]           match_cnt_r, match_cnt_s;
    logic [3:0]           miss_cnt_r,  miss_cnt_s;
    logic [ERR_CNT_W-1:0] err_count_r, err_count_s;
    logic                 mismatch_r,  mismatch_s;
    logic                 locked_r,    locked_s;

    logic [LFSR_W-1:0]    predicted_s;
    logic                 hit_s;

    // Prediction uses the live seed so a seed change applies at the next lockup reload.
    always_comb begin
        predicted_s = lfsr3_next(prev_r, seed);
        hit_s       = (sample == predicted_s);
    end

    // Next-state and counter updates; idle cycles hold everything and keep mismatch low.
    always_comb begin
        state_s     = state_r;
        prev_s      = prev_r;
        match_cnt_s = match_cnt_r;
        miss_cnt_s  = miss_cnt_r;
        err_count_s = err_count_r;
        mismatch_s  = 1'b0;

        if (sample_valid) begin
            prev_s = sample;
            case (state_r)
                HUNT: begin
                    state_s     = VERIFY;
                    match_cnt_s = 4'd0;
                end
                VERIFY: begin
                    if (hit_s) begin
                        match_cnt_s = match_cnt_r + 4'd1;
                        if ((match_cnt_r + 4'd1) == LOCK_TARGET) begin
                            state_s    = LOCKED;
                            miss_cnt_s = 4'd0;
                        end else begin
                            state_s = VERIFY;
                        end
                    end else begin
                        // Resync: this sample becomes the new reference for the next prediction.
                        match_cnt_s = 4'd0;
                    end
                end
                LOCKED: begin
                    if (hit_s) begin
                        miss_cnt_s = 4'd0;
                    end else begin
                        mismatch_s = 1'b1;
                        if (err_count_r != ERR_MAX) begin
                            err_count_s = err_count_r + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
                        end else begin
                            err_count_s = err_count_r;
                        end
                        if ((miss_cnt_r + 4'd1) == LOSS_TARGET) begin
                            state_s     = HUNT;
                            match_cnt_s = 4'd0;
                            miss_cnt_s  = 4'd0;
                        end else begin
                            miss_cnt_s = miss_cnt_r + 4'd1;
                        end
                    end
                end
                default: begin
                    state_s     = HUNT;
                    match_cnt_s = 4'd0;
                    miss_cnt_s  = 4'd0;
                end
            endcase
        end else begin
            state_s = state_r;
        end

        locked_s = (state_s == LOCKED);
    end

    // State and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r     <= HUNT;
            prev_r      <= 3'b000;
            match_cnt_r <= 4'd0;
            miss_cnt_r  <= 4'd0;
            err_count_r <= {ERR_CNT_W{1'b0}};
            mismatch_r  <= 1'b0;
            locked_r    <= 1'b0;
        end else begin
            state_r     <= state_s;
            prev_r      <= prev_s;
            match_cnt_r <= match_cnt_s;
            miss_cnt_r  <= miss_cnt_s;
            err_count_r <= err_count_s;
            mismatch_r  <= mismatch_s;
            locked_r    <= locked_s;
        end
    end

    assign locked    = locked_r;
    assign mismatch  = mismatch_r;
    assign err_count = err_count_r;

`ifdef LFSR_CHK_SAMPLE_CNT_EN
    logic [15:0] sample_count_r;

    // Wrapping count of every accepted sample, independent of lock state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sample_count_r <= 16'd0;
        end else if (sample_valid) begin
            sample_count_r <= sample_count_r + 16'd1;
        end else begin
            sample_count_r <= sample_count_r;
        end
    end

    assign sample_count = sample_count_r;
`endif

endmodule

// File: tb/tb_lfsr_3bits_checker.sv
// Self-checking bench for lfsr_3bits_checker: directed scenarios plus a randomized stream
// compared against a run-length reference model; a second instance has a 2-bit err_count.
module tb_lfsr_3bits_checker;

    localparam int LOCK_N = 4;
    localparam int LOSS_N = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] seed = 3'b001;
    logic       sample_valid = 1'b0;
    logic [2:0] sample = 3'b000;

    logic       locked,  mismatch;
    logic [7:0] err_count;
    logic       locked2, mismatch2;
    logic [1:0] err_count2;
`ifdef LFSR_CHK_SAMPLE_CNT_EN
    logic [15:0] sample_count, sample_count2;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: "have a reference sample", length of the current good run, lock flag.
    int m_have, m_prev, m_run, m_locked, m_miss, m_err, m_err2, m_mis, m_scnt;

    always #5 clock = ~clock;

    lfsr_3bits_checker #(.LOCK_COUNT(4), .LOSS_COUNT(2), .ERR_CNT_W(8)) dut (
        .clock(clock), .reset(reset), .seed(seed), .sample_valid(sample_valid),
        .sample(sample), .locked(locked), .mismatch(mismatch),
`ifdef LFSR_CHK_SAMPLE_CNT_EN
        .sample_count(sample_count),
`endif
        .err_count(err_count)
    );

    lfsr_3bits_checker #(.LOCK_COUNT(4), .LOSS_COUNT(2), .ERR_CNT_W(2)) dut_sat (
        .clock(clock), .reset(reset), .seed(seed), .sample_valid(sample_valid),
        .sample(sample), .locked(locked2), .mismatch(mismatch2),
`ifdef LFSR_CHK_SAMPLE_CNT_EN
        .sample_count(sample_count2),
`endif
        .err_count(err_count2)
    );

    // Next value of the XNOR recurrence, written arithmetically; 7 is the lockup value.
    function automatic int ref_next(int p, int sd);
        if (p == 7) return sd;
        return ((p * 2) % 8) + ((((p >> 2) & 1) == ((p >> 1) & 1)) ? 1 : 0);
    endfunction

    task automatic model_reset();
        m_have = 0; m_prev = 0; m_run = 0; m_locked = 0; m_miss = 0;
        m_err = 0; m_err2 = 0; m_mis = 0; m_scnt = 0;
    endtask

    task automatic model_step(input int v, input int s, input int sd);
        m_mis = 0;
        if (v != 0) begin
            m_scnt = (m_scnt + 1) % 65536;
            if (m_have == 0) begin
                m_have = 1;
                m_run  = 0;
            end else if (m_locked == 0) begin
                if (s == ref_next(m_prev, sd)) begin
                    m_run = m_run + 1;
                    if (m_run == LOCK_N) begin
                        m_locked = 1;
                        m_miss   = 0;
                    end
                end else begin
                    m_run = 0;
                end
            end else if (s == ref_next(m_prev, sd)) begin
                m_miss = 0;
            end else begin
                m_mis = 1;
                if (m_err < 255) m_err = m_err + 1;
                if (m_err2 < 3) m_err2 = m_err2 + 1;
                m_miss = m_miss + 1;
                if (m_miss == LOSS_N) begin
                    m_locked = 0; m_have = 0; m_run = 0; m_miss = 0;
                end
            end
            m_prev = s;
        end
    endtask

    task automatic step(input logic v, input logic [2:0] s);
        sample_valid = v;
        sample       = s;
        @(posedge clock);
        model_step(int'(v), int'(s), int'(seed));
        #1;
    endtask

    task automatic apply_reset();
        @(posedge clock);
        #2 reset = 1'b1;
        model_reset();
        sample_valid = 1'b0;
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic drive_lock_stream(input logic [2:0] sd);
        logic [2:0] v;
        seed = sd;
        v = sd;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, v);
            v = 3'(ref_next(int'(v), int'(sd)));
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #23;
        tests_run++;
        if ({locked, mismatch, err_count, locked2, err_count2} !== 13'd0) begin
            tests_failed++;
            $display("FAIL reset_state: got locked=%0b mismatch=%0b err=%0d err2=%0d, want all 0",
                     locked, mismatch, err_count, err_count2);
        end
        model_reset();
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic test_lock_acquire();
        logic [2:0] stream [5];
        stream = '{3'b001, 3'b011, 3'b110, 3'b101, 3'b010};
        apply_reset();
        seed = 3'b001;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, stream[i]);
            tests_run++;
            if (locked !== (i == 4) || mismatch !== 1'b0) begin
                tests_failed++;
                $display("FAIL lock_acquire[%0d]: got locked=%0b mismatch=%0b, want locked=%0b mismatch=0",
                         i, locked, mismatch, (i == 4));
            end
        end
        tests_run++;
        if (err_count !== 8'd0) begin
            tests_failed++;
            $display("FAIL lock_acquire_err: got %0d, want 0", err_count);
        end
    endtask

    task automatic test_single_error();
        step(1'b1, 3'b111);
        tests_run++;
        if (mismatch !== 1'b1 || err_count !== 8'd1 || locked !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_error_miss: got mismatch=%0b err=%0d locked=%0b, want 1 1 1",
                     mismatch, err_count, locked);
        end
        step(1'b1, 3'b001);
        tests_run++;
        if (mismatch !== 1'b0 || err_count !== 8'd1 || locked !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_error_recover: got mismatch=%0b err=%0d locked=%0b, want 0 1 1",
                     mismatch, err_count, locked);
        end
        step(1'b0, 3'b110);
        tests_run++;
        if (mismatch !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_error_idle: got mismatch=%0b, want 0", mismatch);
        end
    endtask

    task automatic test_loss_of_lock();
        logic [2:0] v;
        apply_reset();
        drive_lock_stream(3'b001);
        step(1'b1, 3'b000);
        tests_run++;
        if (mismatch !== 1'b1 || err_count !== 8'd1 || locked !== 1'b1) begin
            tests_failed++;
            $display("FAIL loss_first_miss: got mismatch=%0b err=%0d locked=%0b, want 1 1 1",
                     mismatch, err_count, locked);
        end
        step(1'b1, 3'b111);
        tests_run++;
        if (mismatch !== 1'b1 || err_count !== 8'd2 || locked !== 1'b0) begin
            tests_failed++;
            $display("FAIL loss_second_miss: got mismatch=%0b err=%0d locked=%0b, want 1 2 0",
                     mismatch, err_count, locked);
        end
        // Back in HUNT: a capture plus LOCK_N correct successors relocks, and err_count persists.
        v = 3'b011;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, v);
            v = 3'(ref_next(int'(v), int'(seed)));
            tests_run++;
            if (locked !== (i == 4) || mismatch !== 1'b0 || err_count !== 8'd2) begin
                tests_failed++;
                $display("FAIL loss_relock[%0d]: got locked=%0b mismatch=%0b err=%0d, want %0b 0 2",
                         i, locked, mismatch, err_count, (i == 4));
            end
        end
    endtask

    task automatic test_lockup_reload();
        logic [2:0] stream [5];
        stream = '{3'b111, 3'b101, 3'b010, 3'b100, 3'b000};
        apply_reset();
        seed = 3'b101;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, stream[i]);
            tests_run++;
            if (locked !== (i == 4) || mismatch !== 1'b0) begin
                tests_failed++;
                $display("FAIL lockup_reload[%0d]: got locked=%0b mismatch=%0b, want %0b 0",
                         i, locked, mismatch, (i == 4));
            end
        end
    endtask

    task automatic test_gaps_and_reset();
        logic [2:0] v;
        apply_reset();
        seed = 3'b001;
        v = 3'b001;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, v);
            v = 3'(ref_next(int'(v), 1));
            for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
                step(1'b0, 3'($urandom));
                tests_run++;
                if (locked !== (i == 4) || mismatch !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL gaps[%0d]: got locked=%0b mismatch=%0b, want %0b 0",
                             i, locked, mismatch, (i == 4));
                end
            end
        end
        step(1'b1, 3'b111);
        #2 reset = 1'b1;
        #1;
        tests_run++;
        if (locked !== 1'b0 || mismatch !== 1'b0 || err_count !== 8'd0) begin
            tests_failed++;
            $display("FAIL async_reset: got locked=%0b mismatch=%0b err=%0d, want 0 0 0",
                     locked, mismatch, err_count);
        end
        model_reset();
        @(posedge clock);
        #1 reset = 1'b0;
        // First sample after release is a HUNT capture; only then does verification begin.
        v = 3'b100;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, v);
            v = 3'(ref_next(int'(v), 1));
            tests_run++;
            if (locked !== (i == 4)) begin
                tests_failed++;
                $display("FAIL post_reset_hunt[%0d]: got locked=%0b, want %0b", i, locked, (i == 4));
            end
        end
    endtask

    task automatic test_saturation();
        logic [2:0] good, bad;
        apply_reset();
        drive_lock_stream(3'b001);
        for (int k = 1; k <= 5; k++) begin
            good = 3'(ref_next(m_prev, int'(seed)));
            bad  = good ^ 3'($urandom_range(1, 7));
            step(1'b1, bad);
            step(1'b1, 3'(ref_next(int'(bad), int'(seed))));
            tests_run++;
            if (err_count2 !== 2'((k > 3) ? 3 : k) || err_count !== 8'(k) || locked2 !== 1'b1) begin
                tests_failed++;
                $display("FAIL saturation[%0d]: got err2=%0d err=%0d locked2=%0b, want %0d %0d 1",
                         k, err_count2, err_count, locked2, (k > 3) ? 3 : k, k);
            end
        end
    endtask

    task automatic test_random();
        logic [2:0] s;
        logic       v;
        apply_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 49) == 0) seed = 3'($urandom);
            v = ($urandom_range(0, 3) != 0);
            if (m_have != 0 && $urandom_range(0, 99) < 88) s = 3'(ref_next(m_prev, int'(seed)));
            else s = 3'($urandom);
            step(v, s);
            tests_run++;
            if (locked !== 1'(m_locked) || mismatch !== 1'(m_mis) || err_count !== 8'(m_err) ||
                err_count2 !== 2'(m_err2) || locked2 !== 1'(m_locked) || mismatch2 !== 1'(m_mis)
`ifdef LFSR_CHK_SAMPLE_CNT_EN
                || sample_count !== 16'(m_scnt) || sample_count2 !== 16'(m_scnt)
`endif
                ) begin
                tests_failed++;
                $display("FAIL random[%0d]: got locked=%0b mis=%0b err=%0d err2=%0d, want %0d %0d %0d %0d",
                         n, locked, mismatch, err_count, err_count2, m_locked, m_mis, m_err, m_err2);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_lock_acquire();
        test_single_error();
        test_loss_of_lock();
        test_lockup_reload();
        test_gaps_and_reset();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
